rr_req_tracker: RTL and testbench
=================================

Name: rr_req_tracker

Overview:
Requester-side companion to the round-robin arbiter.
- Collects per-client work-request pulses into saturating pending counters.
- Drives one request line per client into the arbiter and consumes the arbiter's one-hot grant.
- Retires one pending item per accepted grant, reports completions, drops and starvation, and flags protocol violations by the arbiter.
- Sits between client logic and the arbiter; req_o connects to the arbiter's req_i and grant_i to its grant_o.

Parameters:
NUM_REQS, 4, number of clients; must match the arbiter.
CNT_W, 3, width of each pending counter; max pending per client = 2^CNT_W-1 (7).
WAIT_W, 6, width of each per-client wait counter; saturates at 2^WAIT_W-1 (63).
STARVE_LIMIT, 12, wait-cycle threshold for starve_o; must be <= 2^WAIT_W-1.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
push_i  in  NUM_REQS  per-client new-work pulse; one item per cycle high.
grant_i  in  NUM_REQS  grant from arbiter; expected one-hot or zero.
req_o  out  NUM_REQS  request to arbiter; bit k = (pend[k] != 0).
done_o  out  NUM_REQS  registered one-cycle pulse per accepted grant.
full_o  out  NUM_REQS  bit k = (pend[k] == 2^CNT_W-1).
drop_o  out  NUM_REQS  registered one-cycle pulse when a push is discarded.
starve_o  out  NUM_REQS  bit k high while wait[k] >= STARVE_LIMIT.
err_o  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous): pend, wait, done_o, drop_o, starve_o and err_o all clear to 0. req_o and full_o therefore read 0.
  - Reset mid-operation discards all pending items with no done_o.
  - First update occurs on the first rising edge after rst returns to 1.
- Per client k, evaluated each rising edge:
  - gacc = grant_i[k] & req_o[k]. A grant is accepted only while req_o[k] is already high.
  - pacc = push_i[k] & (~full_o[k] | gacc).
  - pend[k] <= pend[k] + pacc - gacc. Never underflows; never exceeds the max.
  - done_o[k] <= gacc.
  - drop_o[k] <= push_i[k] & ~pacc, i.e. a push while full with no grant that cycle.
- Latency:
  - Push at edge N with pend=0: req_o high from edge N onward; earliest accepted grant is at edge N+1.
  - Grant accepted at edge M: done_o high in cycle M..M+1. If pend becomes 0, req_o drops after edge M.
- Simultaneous push and grant on the same client: net pend unchanged, including when full (no drop). req_o stays high.
- Wait counter, per client:
  - If gacc, or req_o[k]=0: wait <= 0.
  - Else: wait <= wait+1, saturating at 2^WAIT_W-1.
  - starve_o[k] is combinational from registered wait; it clears the edge a grant is accepted.
- Protocol errors set err_o at the edge they are sampled:
  - a grant_i bit high while the matching req_o bit is 0 (grant ignored, pend unchanged);
  - grant_i with more than one bit set. Each individually valid bit is still accepted.
- No combinational path from any input to any output; all outputs derive from registers.

Test Plan:
1. Reset, single push: rst=0 for 2 cycles, then 1; push_i=0001 for one cycle; grant_i=0001 one cycle later -> req_o=0001 for exactly one cycle, done_o=0001 one cycle after the grant, req_o=0000, err_o=0.
2. Saturation and drop: push_i=0010 for 9 consecutive cycles, no grants -> full_o[1]=1 after the 7th push; drop_o[1] pulses for pushes 8 and 9; pend stays 7. Then one grant on bit 1 -> full_o[1]=0.
3. Push and grant while full: client 2 full (7), push_i=0100 and grant_i=0100 in the same cycle -> pend stays 7, done_o=0100, drop_o=0000.
4. Starvation: push_i=1000 once, no grant for 14 cycles -> starve_o[3] rises when wait reaches 12. Grant 1000 -> starve_o[3]=0 at that edge, done_o=1000.
5. Protocol errors: with req_o=0001, drive grant_i=0100 -> err_o=1, pend unchanged. After reset, grant_i=0011 with req_o=0011 -> both bits accepted, done_o=0011, err_o=1.
6. Round-robin loop with arbiter: connect to rr_arbiter (NUM_REQS=4); random push_i for 200 cycles, then stop pushing and run until req_o=0000 -> total done_o pulses = total pushes - total drop_o pulses, err_o=0, starve_o never set.

Source files
------------

// File: rtl/rr_req_tracker.sv
// Requester-side tracker for a round-robin arbiter: per-client pending counters,
// request generation, grant retirement, drop/starve reporting and protocol checking.
module rr_req_tracker #(
  parameter int NUM_REQS     = 4,
  parameter int CNT_W        = 3,
  parameter int WAIT_W       = 6,
  parameter int STARVE_LIMIT = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQS-1:0] push_i,
  input  logic [NUM_REQS-1:0] grant_i,
  output logic [NUM_REQS-1:0] req_o,
  output logic [NUM_REQS-1:0] done_o,
  output logic [NUM_REQS-1:0] full_o,
  output logic [NUM_REQS-1:0] drop_o,
  output logic [NUM_REQS-1:0] starve_o,
  output logic                err_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]    pend_reg [NUM_REQS];
  logic [CNT_W-1:0]    pend_next[NUM_REQS];
  logic [WAIT_W-1:0]   wait_reg [NUM_REQS];
  logic [WAIT_W-1:0]   wait_next[NUM_REQS];
  logic [NUM_REQS-1:0] gacc;
  logic [NUM_REQS-1:0] pacc;
  logic [NUM_REQS-1:0] done_reg;
  logic [NUM_REQS-1:0] drop_reg;
  logic                err_reg;
  logic                err_next;
  logic                stray_grant;
  logic                multi_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_client
      assign req_o[gi]    = (pend_reg[gi] != '0);
      assign full_o[gi]   = (pend_reg[gi] == CNT_MAX);
      assign starve_o[gi] = (wait_reg[gi] >= STARVE_TH);

      assign gacc[gi] = grant_i[gi] & req_o[gi];
      // A grant frees a slot in the same cycle, so a push while full is kept.
      assign pacc[gi] = push_i[gi] & (~full_o[gi] | gacc[gi]);

      always_comb begin
        pend_next[gi] = pend_reg[gi];
        if (pacc[gi] && !gacc[gi]) begin
          pend_next[gi] = pend_reg[gi] + 1'b1;
        end else if (!pacc[gi] && gacc[gi]) begin
          pend_next[gi] = pend_reg[gi] - 1'b1;
        end
      end

      always_comb begin
        wait_next[gi] = '0;
        if (!gacc[gi] && req_o[gi]) begin
          wait_next[gi] = (wait_reg[gi] == WAIT_MAX) ? WAIT_MAX : wait_reg[gi] + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pend_reg[gi] <= '0;
          wait_reg[gi] <= '0;
        end else begin
          pend_reg[gi] <= pend_next[gi];
          wait_reg[gi] <= wait_next[gi];
        end
      end
    end
  endgenerate

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_grant = |(grant_i & (grant_i - NUM_REQS'(1)));
  assign stray_grant = |(grant_i & ~req_o);
  assign err_next    = err_reg | multi_grant | stray_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_reg <= '0;
      drop_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      done_reg <= gacc;
      drop_reg <= push_i & ~pacc;
      err_reg  <= err_next;
    end
  end

  assign done_o = done_reg;
  assign drop_o = drop_reg;
  assign err_o  = err_reg;

endmodule

// File: tb/tb_rr_req_tracker.sv
// Scoreboard bench for rr_req_tracker: directed scenarios, random grants and a
// round-robin arbiter loop, checked cycle by cycle against a counter-level model.
module tb_rr_req_tracker;

  localparam int N        = 4;
  localparam int CNT_MAX  = 7;
  localparam int WAIT_MAX = 63;
  localparam int LIMIT    = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] push_i = '0;
  logic [N-1:0] grant_i = '0;
  logic [N-1:0] req_o, done_o, full_o, drop_o, starve_o;
  logic         err_o;

  always #5 clk = ~clk;

  rr_req_tracker #(.NUM_REQS(N), .CNT_W(3), .WAIT_W(6), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .push_i(push_i), .grant_i(grant_i),
    .req_o(req_o), .done_o(done_o), .full_o(full_o), .drop_o(drop_o),
    .starve_o(starve_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] full;
    logic [N-1:0] drop;
    logic [N-1:0] starve;
    logic         err;
  } obs_t;

  obs_t exp_q[$];

  int       m_pend[N];
  int       m_wcnt[N];
  logic [N-1:0] m_done, m_drop;
  logic     m_err;

  int vectors = 0;
  int miscompares = 0;
  int tb_push_cnt = 0;
  int dut_done_cnt = 0;
  int dut_drop_cnt = 0;
  bit starve_seen = 0;
  int rr_ptr = N - 1;

  function automatic obs_t model_obs();
    obs_t o;
    for (int k = 0; k < N; k++) begin
      o.req[k]    = (m_pend[k] > 0);
      o.full[k]   = (m_pend[k] == CNT_MAX);
      o.starve[k] = (m_wcnt[k] >= LIMIT);
    end
    o.done = m_done;
    o.drop = m_drop;
    o.err  = m_err;
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 0;
      m_wcnt[k] = 0;
    end
    m_done = '0;
    m_drop = '0;
    m_err  = 1'b0;
  endtask

  // One clock edge of the requester, stated in terms of item counts.
  task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] g);
    logic [N-1:0] d, dr;
    bit has_req, acc, take;
    d = '0;
    dr = '0;
    for (int k = 0; k < N; k++) begin
      has_req = (m_pend[k] > 0);
      acc     = g[k] && has_req;
      take    = p[k] && (m_pend[k] < CNT_MAX || acc);
      if (g[k] && !has_req) m_err = 1'b1;
      d[k]  = acc;
      dr[k] = p[k] && !take;
      m_pend[k] = m_pend[k] + (take ? 1 : 0) - (acc ? 1 : 0);
      if (acc || !has_req) m_wcnt[k] = 0;
      else if (m_wcnt[k] < WAIT_MAX) m_wcnt[k] = m_wcnt[k] + 1;
    end
    if ($countones(g) > 1) m_err = 1'b1;
    m_done = d;
    m_drop = dr;
  endtask

  task automatic cycle(input logic [N-1:0] p, input logic [N-1:0] g);
    @(negedge clk);
    push_i  = p;
    grant_i = g;
    tb_push_cnt += $countones(p);
    @(posedge clk);
    model_step(p, g);
    exp_q.push_back(model_obs());
  endtask

  // Reset lands mid-cycle so the clear is visible before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    exp_q.push_back(model_obs());
    repeat (2) @(negedge clk);
    push_i  = '0;
    grant_i = '0;
    rst = 1'b1;
  endtask

  function automatic logic [N-1:0] rr_pick();
    int k;
    for (int i = 1; i <= N; i++) begin
      k = (rr_ptr + i) % N;
      if (m_pend[k] > 0) begin
        rr_ptr = k;
        return N'(1) << k;
      end
    end
    return '0;
  endfunction

  function automatic bit any_pending();
    for (int k = 0; k < N; k++) if (m_pend[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares every presented output set against the scoreboard.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{req: req_o, done: done_o, full: full_o, drop: drop_o, starve: starve_o, err: err_o};
        vectors++;
        dut_done_cnt += $countones(done_o);
        dut_drop_cnt += $countones(drop_o);
        starve_seen = starve_seen | (|starve_o);
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got req=%b done=%b full=%b drop=%b starve=%b err=%b want req=%b done=%b full=%b drop=%b starve=%b err=%b",
                   $time, a.req, a.done, a.full, a.drop, a.starve, a.err,
                   e.req, e.done, e.full, e.drop, e.starve, e.err);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Single push then grant.
    cycle(4'b0001, 4'b0000);
    cycle(4'b0000, 4'b0001);
    cycle(4'b0000, 4'b0000);
    // Saturation and drops on client 1, then one grant.
    repeat (9) cycle(4'b0010, 4'b0000);
    cycle(4'b0000, 4'b0010);
    cycle(4'b0000, 4'b0000);
    // Push and grant together while full on client 2.
    repeat (7) cycle(4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0100);
    cycle(4'b0000, 4'b0000);
    // Starvation on client 3.
    cycle(4'b1000, 4'b0000);
    repeat (14) cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b1000);
    cycle(4'b0000, 4'b0000);

    // Stray grant, then a legal double grant after reset (discarding pending work).
    do_reset();
    cycle(4'b0001, 4'b0000);
    cycle(4'b0000, 4'b0100);
    cycle(4'b0000, 4'b0000);
    do_reset();
    cycle(4'b0011, 4'b0000);
    cycle(4'b0000, 4'b0011);
    cycle(4'b0000, 4'b0000);

    // Random pushes with sparse, unconstrained grants (long waits, errors, saturation).
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(N'($urandom & $urandom), N'($urandom & $urandom & $urandom));
    end

    // Round-robin arbiter loop, then drain.
    do_reset();
    @(negedge clk);
    tb_push_cnt  = 0;
    dut_done_cnt = 0;
    dut_drop_cnt = 0;
    starve_seen  = 0;
    rr_ptr = N - 1;
    for (int i = 0; i < 200; i++) begin
      cycle(N'($urandom), rr_pick());
    end
    for (int i = 0; i < 200 && any_pending(); i++) begin
      cycle(4'b0000, rr_pick());
    end
    cycle(4'b0000, 4'b0000);
    #2;

    vectors++;
    if (req_o !== '0) begin
      miscompares++;
      $display("FAIL drain_req got %b want 0000", req_o);
    end
    vectors++;
    if (dut_done_cnt != tb_push_cnt - dut_drop_cnt) begin
      miscompares++;
      $display("FAIL done_total got %0d want %0d (pushes %0d drops %0d)",
               dut_done_cnt, tb_push_cnt - dut_drop_cnt, tb_push_cnt, dut_drop_cnt);
    end
    vectors++;
    if (err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_err got %b want 0", err_o);
    end
    vectors++;
    if (starve_seen) begin
      miscompares++;
      $display("FAIL rr_starve got 1 want 0");
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
